memory_interface_arbiter: RTL and testbench
===========================================

Name: memory_interface_arbiter

Overview:
- Shares one single-port memory between the core's instruction and data memory interfaces.
- Sits between the phoeniX core and the memory model or on-chip RAM, so the testbench and SoC no longer need two independent ports into one array.
- Serialises requests with a one-outstanding-access FSM.
- Grant policy is fixed data priority with an instruction starvation guard, or round-robin, selected by parameter.

Parameters:
- ADDRESS_WIDTH, 32, width of all address buses
- ROUND_ROBIN, 0, 0 = data side has priority with starvation guard; 1 = alternate grants when both request
- STARVATION_LIMIT, 4, consecutive data grants allowed while instr_req is pending (ROUND_ROBIN=0 only); range 1..15

Ports:
- clk  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- instr_req  in  1  instruction request; held until instr_ready
- instr_write  in  1  1 = write (normally 0)
- instr_address  in  ADDRESS_WIDTH  byte address
- instr_frame_mask  in  4  byte-lane mask; bit3 = byte0 … bit0 = byte3
- instr_wdata  in  32  write data
- instr_rdata  out  32  read data, valid when instr_ready=1
- instr_ready  out  1  one-cycle completion pulse
- data_req, data_write, data_address, data_frame_mask, data_wdata  in  1/1/AW/4/32  same semantics for the data side
- data_rdata  out  32  data-side read data
- data_ready  out  1  data-side completion pulse
- mem_enable  out  1  one-cycle command strobe
- mem_write  out  1  1 = write
- mem_address  out  ADDRESS_WIDTH  forwarded address
- mem_frame_mask  out  4  forwarded mask, unchanged
- mem_wdata  out  32  forwarded write data
- mem_rdata  in  32  memory read data
- mem_valid  in  1  completion from memory, for reads and writes; latency ≥1 cycle after mem_enable
- arbiter_busy  out  1  1 whenever state ≠ IDLE

Behaviour:
- FSM states and transitions:
  - IDLE: on any req, select owner and go to ISSUE.
  - ISSUE: exactly one cycle.
  - WAIT: stay until mem_valid, then go to RESP.
  - RESP: exactly one cycle, then IDLE.
- Command capture: on IDLE→ISSUE, owner's write/address/mask/wdata are registered into mem_*. mem_enable=1 only during ISSUE. mem_* other than mem_enable hold their values until the next ISSUE.
- Response capture: on mem_valid in WAIT, mem_rdata is registered into the owner's rdata. In RESP, the owner's ready=1 for exactly one cycle. The other side's rdata/ready are untouched.
- Write responses: for a write, rdata is not updated; ready still pulses.
- mem_valid timing: mem_valid during ISSUE is accepted; the FSM goes straight to RESP.
- Ignored mem_valid: mem_valid in IDLE or RESP is ignored.
- Latency, mem_valid 1 cycle after mem_enable: req seen at edge N; mem_enable in N+1; mem_valid in N+2; ready in N+3. Back-to-back throughput is one access per 4 cycles.
- Request sampling: req is sampled only in IDLE. A requester that drops req before ready is a protocol violation; the access still completes.
- Priority (ROUND_ROBIN=0):
  - Data wins when both request.
  - 4-bit starve_count increments on each data grant while instr_req=1, and clears on any instruction grant or when instr_req=0 in IDLE.
  - When starve_count==STARVATION_LIMIT and both request, instruction wins.
- Round-robin (ROUND_ROBIN=1):
  - last_owner register; with both requesting, grant the side that is not last_owner.
  - After reset, last_owner=instruction, so data wins first.
- Single requester: always granted regardless of policy.
- Reset (synchronous, any state, including mid-WAIT):
  - state=IDLE, starve_count=0, last_owner=instruction.
  - mem_enable=0, mem_write=0, mem_address=0, mem_frame_mask=0, mem_wdata=0.
  - instr_rdata=0, data_rdata=0, instr_ready=0, data_ready=0, arbiter_busy=0.
  - A stale mem_valid arriving after reset is ignored.
- Invariants:
  - instr_ready and data_ready are never high in the same cycle.
  - mem_enable is never high outside ISSUE.

Test Plan:
- Single instruction read, addr 0x0000_0010, memory returns 0x0000_0013 with latency 1 -> mem_enable at N+1 with mem_write=0; instr_ready one cycle at N+3 with instr_rdata=0x0000_0013; data_ready stays 0.
- Data write addr 0x1000_0000, mask 4'b1000, wdata 0x41 -> mem_write=1, mem_frame_mask=4'b1000, mem_wdata=0x41; data_ready pulses; data_rdata unchanged.
- Both sides held high continuously, ROUND_ROBIN=0, LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; starve_count never exceeds 4.
- Both sides held high, ROUND_ROBIN=1 -> grant order D,I,D,I; each ready pulse attributed to the correct side.
- Memory latency 3 with a read in flight -> FSM stays in WAIT for 3 cycles with arbiter_busy=1 and no second mem_enable; then exactly one ready pulse.
- reset asserted during WAIT, then mem_valid arrives -> all outputs 0 next edge; the late mem_valid produces no ready; a subsequent instr_req completes normally.

Source files
------------

// File: rtl/memory_interface_arbiter_if.sv
// rtl/memory_interface_arbiter_if.sv - instruction, data and memory buses of the memory interface arbiter
interface memory_interface_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     instr_req;
    logic                     instr_write;
    logic [ADDRESS_WIDTH-1:0] instr_address;
    logic [3:0]               instr_frame_mask;
    logic [31:0]              instr_wdata;
    logic [31:0]              instr_rdata;
    logic                     instr_ready;

    logic                     data_req;
    logic                     data_write;
    logic [ADDRESS_WIDTH-1:0] data_address;
    logic [3:0]               data_frame_mask;
    logic [31:0]              data_wdata;
    logic [31:0]              data_rdata;
    logic                     data_ready;

    logic                     mem_enable;
    logic                     mem_write;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [3:0]               mem_frame_mask;
    logic [31:0]              mem_wdata;
    logic [31:0]              mem_rdata;
    logic                     mem_valid;

    logic                     arbiter_busy;

    modport slave (
        input  instr_req, instr_write, instr_address, instr_frame_mask, instr_wdata,
        output instr_rdata, instr_ready,
        input  data_req, data_write, data_address, data_frame_mask, data_wdata,
        output data_rdata, data_ready,
        output mem_enable, mem_write, mem_address, mem_frame_mask, mem_wdata,
        input  mem_rdata, mem_valid,
        output arbiter_busy
    );

    modport master (
        output instr_req, instr_write, instr_address, instr_frame_mask, instr_wdata,
        input  instr_rdata, instr_ready,
        output data_req, data_write, data_address, data_frame_mask, data_wdata,
        input  data_rdata, data_ready,
        input  mem_enable, mem_write, mem_address, mem_frame_mask, mem_wdata,
        output mem_rdata, mem_valid,
        input  arbiter_busy
    );
endinterface

// File: rtl/memory_interface_arbiter.sv
// rtl/memory_interface_arbiter.sv - shares one single-port memory between instruction and data interfaces
module memory_interface_arbiter #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int ROUND_ROBIN      = 0,
    parameter int STARVATION_LIMIT = 4
) (
    input logic                        clk,
    input logic                        reset,
    memory_interface_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LIMIT       = 4'(STARVATION_LIMIT);
    localparam logic       OWNER_INSTR = 1'b0;
    localparam logic       OWNER_DATA  = 1'b1;

    state_t                   state_q;
    logic                     owner_q;
    logic [3:0]               starve_q;
    logic                     mem_enable_q;
    logic                     mem_write_q;
    logic [ADDRESS_WIDTH-1:0] mem_address_q;
    logic [3:0]               mem_frame_mask_q;
    logic [31:0]              mem_wdata_q;
    logic [31:0]              instr_rdata_q;
    logic [31:0]              data_rdata_q;
    logic                     instr_ready_q;
    logic                     data_ready_q;

    logic                     any_req_d;
    logic                     grant_data_d;
    logic [3:0]               starve_d;

    // owner_q doubles as last_owner for the round-robin policy
    always_comb begin
        any_req_d    = bus.instr_req | bus.data_req;
        grant_data_d = 1'b0;
        if (ROUND_ROBIN != 0) begin
            grant_data_d = bus.data_req & (~bus.instr_req | (owner_q == OWNER_INSTR));
        end else begin
            grant_data_d = bus.data_req & ~(bus.instr_req & (starve_q == LIMIT));
        end
        starve_d = (grant_data_d & bus.instr_req) ? starve_q + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            owner_q          <= OWNER_INSTR;
            starve_q         <= 4'd0;
            mem_enable_q     <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_frame_mask_q <= 4'd0;
            mem_wdata_q      <= 32'd0;
            instr_rdata_q    <= 32'd0;
            data_rdata_q     <= 32'd0;
            instr_ready_q    <= 1'b0;
            data_ready_q     <= 1'b0;
        end else begin
            mem_enable_q  <= 1'b0;
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    starve_q <= starve_d;
                    if (any_req_d) begin
                        state_q          <= ISSUE;
                        owner_q          <= grant_data_d;
                        mem_enable_q     <= 1'b1;
                        mem_write_q      <= grant_data_d ? bus.data_write      : bus.instr_write;
                        mem_address_q    <= grant_data_d ? bus.data_address    : bus.instr_address;
                        mem_frame_mask_q <= grant_data_d ? bus.data_frame_mask : bus.instr_frame_mask;
                        mem_wdata_q      <= grant_data_d ? bus.data_wdata      : bus.instr_wdata;
                    end
                end
                ISSUE, WAIT: begin
                    // a response during ISSUE skips WAIT entirely
                    if (bus.mem_valid) begin
                        state_q <= RESP;
                        if (owner_q == OWNER_DATA) begin
                            data_ready_q <= 1'b1;
                            if (!mem_write_q) data_rdata_q <= bus.mem_rdata;
                        end else begin
                            instr_ready_q <= 1'b1;
                            if (!mem_write_q) instr_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        state_q <= WAIT;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_enable     = mem_enable_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_frame_mask = mem_frame_mask_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.instr_rdata    = instr_rdata_q;
    assign bus.instr_ready    = instr_ready_q;
    assign bus.data_rdata     = data_rdata_q;
    assign bus.data_ready     = data_ready_q;
    assign bus.arbiter_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_memory_interface_arbiter.sv
// tb/tb_memory_interface_arbiter.sv - self-checking bench for memory_interface_arbiter
module tb_memory_interface_arbiter;
    localparam int LIMIT = 4;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 1;

    logic        i_req, i_wr, d_req, d_wr;
    logic [31:0] i_addr, i_wd, d_addr, d_wd;
    logic [3:0]  i_mask, d_mask;

    memory_interface_arbiter_if #(.ADDRESS_WIDTH(32)) bus0 ();
    memory_interface_arbiter_if #(.ADDRESS_WIDTH(32)) bus1 ();

    memory_interface_arbiter #(.ADDRESS_WIDTH(32), .ROUND_ROBIN(0), .STARVATION_LIMIT(LIMIT))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));
    memory_interface_arbiter #(.ADDRESS_WIDTH(32), .ROUND_ROBIN(1), .STARVATION_LIMIT(LIMIT))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    assign bus0.instr_req = i_req;   assign bus1.instr_req = i_req;
    assign bus0.instr_write = i_wr;  assign bus1.instr_write = i_wr;
    assign bus0.instr_address = i_addr; assign bus1.instr_address = i_addr;
    assign bus0.instr_frame_mask = i_mask; assign bus1.instr_frame_mask = i_mask;
    assign bus0.instr_wdata = i_wd;  assign bus1.instr_wdata = i_wd;
    assign bus0.data_req = d_req;    assign bus1.data_req = d_req;
    assign bus0.data_write = d_wr;   assign bus1.data_write = d_wr;
    assign bus0.data_address = d_addr; assign bus1.data_address = d_addr;
    assign bus0.data_frame_mask = d_mask; assign bus1.data_frame_mask = d_mask;
    assign bus0.data_wdata = d_wd;   assign bus1.data_wdata = d_wd;

    logic        o_en[2], o_wr[2], o_ir[2], o_dr[2], o_busy[2], mv[2];
    logic [31:0] o_addr[2], o_wd[2], o_ird[2], o_drd[2];
    logic [3:0]  o_mask[2];
    assign o_en[0] = bus0.mem_enable;       assign o_en[1] = bus1.mem_enable;
    assign o_wr[0] = bus0.mem_write;        assign o_wr[1] = bus1.mem_write;
    assign o_addr[0] = bus0.mem_address;    assign o_addr[1] = bus1.mem_address;
    assign o_mask[0] = bus0.mem_frame_mask; assign o_mask[1] = bus1.mem_frame_mask;
    assign o_wd[0] = bus0.mem_wdata;        assign o_wd[1] = bus1.mem_wdata;
    assign o_ird[0] = bus0.instr_rdata;     assign o_ird[1] = bus1.instr_rdata;
    assign o_drd[0] = bus0.data_rdata;      assign o_drd[1] = bus1.data_rdata;
    assign o_ir[0] = bus0.instr_ready;      assign o_ir[1] = bus1.instr_ready;
    assign o_dr[0] = bus0.data_ready;       assign o_dr[1] = bus1.data_ready;
    assign o_busy[0] = bus0.arbiter_busy;   assign o_busy[1] = bus1.arbiter_busy;

    // memory: returns address+3, mem_valid lat cycles after mem_enable (lat 0 = same cycle); not reset
    int mcnt[2];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_en[k] && lat != 0) mcnt[k] <= lat;
            else if (mcnt[k] != 0)   mcnt[k] <= mcnt[k] - 1;
        end
    end
    assign mv[0] = (mcnt[0] == 1) || (lat == 0 && bus0.mem_enable);
    assign mv[1] = (mcnt[1] == 1) || (lat == 0 && bus1.mem_enable);
    assign bus0.mem_valid = mv[0];
    assign bus1.mem_valid = mv[1];
    assign bus0.mem_rdata = bus0.mem_address + 32'd3;
    assign bus1.mem_rdata = bus1.mem_address + 32'd3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // transaction-level model: k=0 data priority with starvation guard, k=1 round-robin
    logic        m_fly[2], m_resp[2], m_own[2], m_prev[2], gd[2], armed;
    int          m_run[2];
    logic        e_en[2], e_wr[2], e_ir[2], e_dr[2];
    logic [31:0] e_addr[2], e_wd[2], e_ird[2], e_drd[2];
    logic [3:0]  e_mask[2];

    function automatic logic wins_data(input int k, input int run, input logic prev_data);
        if (!d_req) return 1'b0;
        if (!i_req) return 1'b1;
        if (k == 1) return !prev_data;
        return run < LIMIT;
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) gd[k] = wins_data(k, m_run[k], m_prev[k]);
    end

    initial armed = 1'b0;
    always @(posedge clk) begin
        if (reset) armed <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            e_en[k] <= 1'b0;
            e_ir[k] <= 1'b0;
            e_dr[k] <= 1'b0;
            if (reset) begin
                m_fly[k] <= 1'b0; m_resp[k] <= 1'b0; m_own[k] <= 1'b0; m_prev[k] <= 1'b0;
                m_run[k] <= 0; e_wr[k] <= 1'b0; e_addr[k] <= 32'd0; e_mask[k] <= 4'd0;
                e_wd[k] <= 32'd0; e_ird[k] <= 32'd0; e_drd[k] <= 32'd0;
            end else if (m_resp[k]) begin
                m_resp[k] <= 1'b0;
                m_fly[k]  <= 1'b0;
            end else if (m_fly[k]) begin
                if (mv[k]) begin
                    m_resp[k] <= 1'b1;
                    if (m_own[k]) begin
                        e_dr[k] <= 1'b1;
                        if (!e_wr[k]) e_drd[k] <= e_addr[k] + 32'd3;
                    end else begin
                        e_ir[k] <= 1'b1;
                        if (!e_wr[k]) e_ird[k] <= e_addr[k] + 32'd3;
                    end
                end
            end else if (i_req || d_req) begin
                m_fly[k]  <= 1'b1;
                m_own[k]  <= gd[k];
                m_prev[k] <= gd[k];
                e_en[k]   <= 1'b1;
                e_wr[k]   <= gd[k] ? d_wr   : i_wr;
                e_addr[k] <= gd[k] ? d_addr : i_addr;
                e_mask[k] <= gd[k] ? d_mask : i_mask;
                e_wd[k]   <= gd[k] ? d_wd   : i_wd;
                m_run[k]  <= (gd[k] && i_req) ? m_run[k] + 1 : 0;
            end else begin
                m_run[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d.mem_enable", k), 32'(o_en[k]), 32'(e_en[k]));
                chk($sformatf("dut%0d.mem_write", k), 32'(o_wr[k]), 32'(e_wr[k]));
                chk($sformatf("dut%0d.mem_address", k), o_addr[k], e_addr[k]);
                chk($sformatf("dut%0d.mem_frame_mask", k), 32'(o_mask[k]), 32'(e_mask[k]));
                chk($sformatf("dut%0d.mem_wdata", k), o_wd[k], e_wd[k]);
                chk($sformatf("dut%0d.instr_rdata", k), o_ird[k], e_ird[k]);
                chk($sformatf("dut%0d.data_rdata", k), o_drd[k], e_drd[k]);
                chk($sformatf("dut%0d.instr_ready", k), 32'(o_ir[k]), 32'(e_ir[k]));
                chk($sformatf("dut%0d.data_ready", k), 32'(o_dr[k]), 32'(e_dr[k]));
                chk($sformatf("dut%0d.arbiter_busy", k), 32'(o_busy[k]), 32'(m_fly[k]));
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_reqs();
        i_req = 0; i_wr = 0; i_addr = 0; i_mask = 0; i_wd = 0;
        d_req = 0; d_wr = 0; d_addr = 0; d_mask = 0; d_wd = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // one access on instance 0's handshake; cyc = cycles from request to ready observed
    task automatic access(input bit side_data, input bit wr, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wd,
                          output int cyc, output int ens, output int first_en);
        bit done = 0;
        @(posedge clk); #2;
        if (side_data) begin d_req = 1; d_wr = wr; d_addr = addr; d_mask = mask; d_wd = wd; end
        else           begin i_req = 1; i_wr = wr; i_addr = addr; i_mask = mask; i_wd = wd; end
        cyc = 0; ens = 0; first_en = 0;
        while (!done && cyc < 50) begin
            @(posedge clk); #2;
            cyc++;
            if (o_en[0]) begin ens++; if (first_en == 0) first_en = cyc; end
            if (side_data ? o_dr[0] : o_ir[0]) done = 1;
        end
        chk("access_completed", 32'(done), 32'd1);
        i_req = 0; d_req = 0;
    endtask

    int cyc, ens, first_en, nrdy;
    bit q0[$], q1[$];
    logic [9:0] exp_rr0, exp_rr1;

    initial begin
        clear_reqs();
        do_reset();
        chk("reset_mem_enable", 32'(bus0.mem_enable), 32'd0);
        chk("reset_busy", 32'(bus0.arbiter_busy), 32'd0);
        chk("reset_instr_rdata", bus0.instr_rdata, 32'd0);
        chk("reset_mem_address", bus0.mem_address, 32'd0);

        lat = 1;
        access(0, 0, 32'h0000_0010, 4'b1111, 32'd0, cyc, ens, first_en);
        chk("t1_enable_cycle", 32'(first_en), 32'd1);
        chk("t1_ready_cycle", 32'(cyc), 32'd3);
        chk("t1_enable_count", 32'(ens), 32'd1);
        chk("t1_instr_rdata", bus0.instr_rdata, 32'h0000_0013);
        chk("t1_mem_write", 32'(bus0.mem_write), 32'd0);

        access(1, 1, 32'h1000_0000, 4'b1000, 32'h41, cyc, ens, first_en);
        chk("t2_ready_cycle", 32'(cyc), 32'd3);
        chk("t2_mem_write", 32'(bus0.mem_write), 32'd1);
        chk("t2_mem_mask", 32'(bus0.mem_frame_mask), 32'b1000);
        chk("t2_mem_wdata", bus0.mem_wdata, 32'h41);
        chk("t2_data_rdata_kept", bus0.data_rdata, 32'd0);
        chk("t2_instr_rdata_kept", bus0.instr_rdata, 32'h13);

        lat = 0;
        access(1, 0, 32'h0000_0050, 4'b1111, 32'd0, cyc, ens, first_en);
        chk("t_issue_valid_cycle", 32'(cyc), 32'd2);
        chk("t_issue_valid_rdata", bus0.data_rdata, 32'h53);

        lat = 3;
        access(0, 0, 32'h0000_0020, 4'b1111, 32'd0, cyc, ens, first_en);
        chk("t3_ready_cycle", 32'(cyc), 32'd5);
        chk("t3_enable_count", 32'(ens), 32'd1);
        chk("t3_instr_rdata", bus0.instr_rdata, 32'h23);
        nrdy = 0;
        repeat (4) begin @(posedge clk); #2; if (o_ir[0] || o_dr[0]) nrdy++; end
        chk("t3_single_ready", 32'(nrdy), 32'd0);

        @(posedge clk); #2;
        d_req = 1; d_wr = 0; d_addr = 32'h30; d_mask = 4'b1111;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("t4_busy_in_wait", 32'(bus0.arbiter_busy), 32'd1);
        reset = 1; d_req = 0;
        @(posedge clk); #2;
        chk("t4_rst_busy", 32'(bus0.arbiter_busy), 32'd0);
        chk("t4_rst_mem_address", bus0.mem_address, 32'd0);
        chk("t4_rst_mem_mask", 32'(bus0.mem_frame_mask), 32'd0);
        chk("t4_rst_mem_wdata", bus0.mem_wdata, 32'd0);
        chk("t4_rst_instr_rdata", bus0.instr_rdata, 32'd0);
        chk("t4_rst_data_rdata", bus0.data_rdata, 32'd0);
        reset = 0;
        nrdy = 0;
        repeat (6) begin @(posedge clk); #2; if (o_ir[0] || o_dr[0] || o_ir[1] || o_dr[1]) nrdy++; end
        chk("t4_stale_valid_ignored", 32'(nrdy), 32'd0);
        access(0, 0, 32'h0000_0044, 4'b1111, 32'd0, cyc, ens, first_en);
        chk("t4_after_reset_cycle", 32'(cyc), 32'd5);
        chk("t4_after_reset_rdata", bus0.instr_rdata, 32'h47);

        lat = 1;
        do_reset();
        i_addr = 32'h100; d_addr = 32'h200; i_mask = 4'b1111; d_mask = 4'b0011;
        i_req = 1; d_req = 1;
        cyc = 0;
        while (q0.size() < 10 && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
            if (o_dr[0]) q0.push_back(1'b1);
            if (o_ir[0]) q0.push_back(1'b0);
            if (o_dr[1]) q1.push_back(1'b1);
            if (o_ir[1]) q1.push_back(1'b0);
        end
        i_req = 0; d_req = 0;
        repeat (6) @(posedge clk);
        #2;
        chk("rr0_grant_count", 32'(q0.size()), 32'd10);
        chk("rr1_grant_count", 32'(q1.size()), 32'd10);
        exp_rr0 = 10'b1111011110;
        exp_rr1 = 10'b1010101010;
        for (int j = 0; j < 10; j++) begin
            if (j < q0.size()) chk($sformatf("prio_grant%0d", j), 32'(q0[j]), 32'(exp_rr0[9-j]));
            if (j < q1.size()) chk($sformatf("rr_grant%0d", j), 32'(q1[j]), 32'(exp_rr1[9-j]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
